// File: rtl/comb_decimator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | comb_decimator                                                           |
// | Keeps every DECIM-th integrator sample and applies an M-delay comb with  |
// | a valid/ready output register. Define COMB_SAT_EN for saturating output. |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module comb_decimator #(
  parameter int WIDTH = 22,
  parameter int DECIM = 8,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun
);

  localparam int PH_W = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int FILL_W = $clog2(DELAY + 1);
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIM - 1);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(DELAY);

  logic [PH_W-1:0]   ph;
  logic [FILL_W-1:0] fill;
  logic [WIDTH-1:0]  dline [DELAY];
  logic              dec_event;
  logic              res_event;
  logic [WIDTH-1:0]  y;

  assign dec_event = in_valid && (ph == PH_LAST);
  assign res_event = dec_event && (fill == FILL_FULL);

`ifdef COMB_SAT_EN
  logic signed [WIDTH:0] diff;

  assign diff = $signed({in_data[WIDTH-1], in_data})
              - $signed({dline[DELAY-1][WIDTH-1], dline[DELAY-1]});

  // Sign bit disagreeing with the extra MSB means the true difference left the WIDTH range.
  always_comb begin
    y = diff[WIDTH-1:0];
    if (diff[WIDTH] != diff[WIDTH-1])
      y = diff[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  // Modulo difference: cancels wrap-around of the upstream integrator.
  assign y = in_data - dline[DELAY-1];
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      ph        <= '0;
      fill      <= '0;
      for (int i = 0; i < DELAY; i++) dline[i] <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (in_valid)
        ph <= (ph == PH_LAST) ? '0 : ph + PH_W'(1);

      if (dec_event) begin
        if (fill != FILL_FULL) fill <= fill + FILL_W'(1);
        dline[0] <= in_data;
        for (int i = 1; i < DELAY; i++) dline[i] <= dline[i-1];
      end

      // A result that finds the register occupied and not being consumed is dropped.
      if (res_event) begin
        if (!out_valid || out_ready) begin
          out_data  <= y;
          out_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: doc/comb_decimator.md
# comb_decimator

Downstream stage of the integrator: it consumes the integrator's 22-bit signed fixed-point output stream (20 fractional bits) and keeps every DECIM-th sample. It applies a comb (differentiator) with differential delay DELAY to those samples, then presents each result through a valid/ready output register. Integrator plus this block form one CIC-style decimating stage; the modulo arithmetic here cancels integrator wrap-around.

## Interface
- WIDTH, 22, sample width, two's complement, 20 fractional bits (1 LSB = 2^-20)
- DECIM, 8, decimation ratio R, legal 2..64
- DELAY, 2, comb differential delay M in decimated samples, legal 1..4
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- in_data  in  WIDTH  integrator output sample
- in_valid  in  1  in_data valid this cycle (integrator drives 1 every cycle)
- out_data  out  WIDTH  comb result
- out_valid  out  1  out_data holds an unconsumed result
- out_ready  in  1  consumer accepts out_data when out_valid && out_ready
- overrun  out  1  sticky: a result was dropped because the output was still occupied

## Operation
- Phase counter `ph`, range 0..DECIM-1. It advances only on in_valid and wraps DECIM-1 -> 0.
- Decimation event: in_valid && ph==DECIM-1. in_data at that cycle is decimated sample x[n].
- Delay line: DELAY registers holding x[n-1]..x[n-DELAY], shifted on each decimation event.
- Fill counter, 0..DELAY, saturating. Each decimation event increments it. A result exists only when fill==DELAY at the event, so the first DELAY decimated samples produce no output.
- Result y = x[n] - x[n-DELAY], computed at WIDTH+1 bits and reduced to WIDTH per Configuration.
- Output register, loaded on a result event:
  - out_valid==0: load y, set out_valid.
  - out_valid==1 && out_ready==1 in the same cycle: the old value is consumed and y is loaded; out_valid stays 1.
  - out_valid==1 && out_ready==0: y is dropped, old out_data is kept, overrun is set.
- out_valid==1 && out_ready==1 with no result event clears out_valid. out_data retains its value.
- The delay line and fill counter advance on every decimation event, whether or not the result is dropped.
- overrun is cleared only by reset.
- Reset mid-operation: in the cycle after reset is sampled high, the following all read 0: ph, fill, every delay register, out_data, out_valid, overrun. Any pending result is lost. in_valid is ignored while reset=1.

## Timing
- Reset values: out_data=0, out_valid=0, overrun=0.
- Latency: for an event at rising edge t, out_data/out_valid update at edge t and are visible in the cycle after it. That is one register stage, and no combinational path runs from in_data to out_data.
- Throughput with in_valid always 1: one result per DECIM clocks once the delay line is primed.
- The first output corresponds to decimated sample index DELAY, which is input sample index DECIM·(DELAY+1)-1 after reset.
- out_ready has no combinational path to any output.
- A consumer with out_ready tied to 1 never sees overrun.

## Configuration
- COMB_SAT_EN, when defined:
  - y is saturated to the WIDTH range, +2^(WIDTH-1)-1 to -2^(WIDTH-1), i.e. 0x1FFFFF / 0x200000.
  - Use only when the upstream does not wrap.
- COMB_SAT_EN undefined (default):
  - y is the WIDTH LSBs of the difference (modulo 2^WIDTH).
  - This is required for correct CIC operation with a wrapping integrator.

## Test plan
Defaults: DECIM=8, DELAY=2, out_ready=1 unless stated.
- **Reset:** hold reset 3 cycles with in_valid=1 and random in_data -> out_valid=0, out_data=0, overrun=0 throughout, and the first decimation event occurs 8 valid cycles after release.
- **Ramp:** in_data = k·1024 at valid cycle k=0,1,2… ->
  - no output for k=7 and k=15;
  - first out_data = 23552-7168 = 16384 (0x004000) one cycle after k=23;
  - then 16384 every 8 cycles.
- **Wrap, default build:** decimated samples 0x1F0000, 0x1F8000, 0x201000 (k=7, 15, 23) -> out_data = 0x011000, i.e. (0x201000-0x1F0000) mod 2^22.
- **Same stimulus with COMB_SAT_EN defined:** out_data = 0x200000 (negative saturation).
- **Backpressure:** ramp stimulus with out_ready=0 from k=20 to k=40 ->
  - first result held at 0x004000;
  - result from k=31 dropped and overrun=1 from the cycle after k=31;
  - after out_ready returns to 1 at k=40, the next result appears one cycle after k=47 with value 0x004000;
  - overrun stays 1.
- **Simultaneous accept/load:** out_ready pulsed high exactly in the k=31 event cycle while holding k=23's result -> new value loaded, out_valid stays 1, overrun stays 0.
- **Gapped input:** in_valid=1 every other cycle with the ramp -> identical out_data sequence to the continuous ramp case, with outputs spaced 16 clocks apart.
